// File: rtl/sdram_data_path_if.sv
// Bank-side and pin-side bus of the SDRAM data-path slice.
// The controller/bench drives the master side and the data path sits on the slave side.
interface sdram_data_path_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned NB = 4
);
  localparam int unsigned BW = DW / 8;

  logic [NB-1:0]    data_fetch;
  logic [NB-1:0]    rd_fetch;
  logic [NB*BW-1:0] wr_bena;
  logic [NB*DW-1:0] wr_data;
  logic [DW-1:0]    rd_data;
  logic [NB-1:0]    rd_valid;
  logic             err_clr;
  logic             err_multi;
  logic             err_coll;
  logic [BW-1:0]    sdram_dqm_n;
  logic             sdram_dq_oe;
  logic [DW-1:0]    sdram_dq_o;
  logic [DW-1:0]    sdram_dq_i;

  modport master (
    output data_fetch, rd_fetch, wr_bena, wr_data, err_clr, sdram_dq_i,
    input  rd_data, rd_valid, err_multi, err_coll, sdram_dqm_n, sdram_dq_oe, sdram_dq_o
  );

  modport slave (
    input  data_fetch, rd_fetch, wr_bena, wr_data, err_clr, sdram_dq_i,
    output rd_data, rd_valid, err_multi, err_coll, sdram_dqm_n, sdram_dq_oe, sdram_dq_o
  );
endinterface

// File: rtl/sdram_data_path.sv
// SDRAM data-path slice: latency-aligned write data selection into a registered DQ/DQM
// pipeline, tagged read capture, and sticky overlap/collision error flags.
module sdram_data_path #(
  parameter int unsigned DW      = 32,
  parameter int unsigned NB      = 4,
  parameter int unsigned WR_LAT  = 2,
  parameter int unsigned RD_LAT  = 4,
  parameter real         TCO_DLY = 4.5
) (
  input logic              clk,
  input logic              rst,
  sdram_data_path_if.slave bus
);
  localparam int unsigned BW = DW / 8;

  if (DW == 0 || (DW % 8) != 0) begin : g_bad_dw
    $error("DW must be a non-zero multiple of 8");
  end
  if (NB < 1 || NB > 8) begin : g_bad_nb
    $error("NB must be in 1..8");
  end
  if (WR_LAT < 1 || WR_LAT > 6) begin : g_bad_wr_lat
    $error("WR_LAT must be in 1..6");
  end
  if (RD_LAT < 2 || RD_LAT > 8) begin : g_bad_rd_lat
    $error("RD_LAT must be in 2..8");
  end
  if (TCO_DLY < 0.0) begin : g_bad_tco
    $error("TCO_DLY must not be negative");
  end

  function automatic logic multi_hot(input logic [NB-1:0] v);
    return (v & (v - NB'(1))) != '0;
  endfunction

  logic [NB-1:0] fe_q [WR_LAT];
  logic [NB-1:0] rs_q [RD_LAT];
  logic [NB-1:0] fe_s;

  logic [DW-1:0] a_data_q;
  logic [BW-1:0] a_dqm_n_q;
  logic          a_oe_q;
  logic [DW-1:0] dq_o_q;
  logic [BW-1:0] dqm_n_q;
  logic          dq_oe_q;
  logic [DW-1:0] rd_data_q;

  logic          err_multi_q, err_multi_d;
  logic          err_coll_q, err_coll_d;

  logic [DW-1:0] sel_data;
  logic [BW-1:0] sel_bena;
  logic          multi_ev;
  logic          coll_ev;

  assign fe_s = fe_q[WR_LAT-1];

  // AND-OR merge of every bank whose fetch tag reaches the sample cycle.
  always_comb begin
    sel_data = '0;
    sel_bena = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (fe_s[b]) begin
        sel_data = sel_data | bus.wr_data[b*DW +: DW];
        sel_bena = sel_bena | bus.wr_bena[b*BW +: BW];
      end
    end
    if (fe_s == '0) begin
      sel_bena = '1;
    end
  end

  assign multi_ev = multi_hot(bus.data_fetch) | multi_hot(bus.rd_fetch);
  // A read whose tag is one stage from rd_valid is being sampled off the pins right now.
  assign coll_ev  = dq_oe_q & (|rs_q[RD_LAT-2]);

  always_comb begin
    err_multi_d = err_multi_q;
    err_coll_d  = err_coll_q;
    if (bus.err_clr) begin
      err_multi_d = 1'b0;
      err_coll_d  = 1'b0;
    end
    if (multi_ev) err_multi_d = 1'b1;
    if (coll_ev)  err_coll_d  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WR_LAT; i++) fe_q[i] <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) rs_q[i] <= '0;
      a_data_q    <= '0;
      a_dqm_n_q   <= '0;
      a_oe_q      <= 1'b0;
      dq_o_q      <= '0;
      dqm_n_q     <= '0;
      dq_oe_q     <= 1'b0;
      rd_data_q   <= '0;
      err_multi_q <= 1'b0;
      err_coll_q  <= 1'b0;
    end else begin
      fe_q[0] <= bus.data_fetch;
      for (int unsigned i = 1; i < WR_LAT; i++) fe_q[i] <= fe_q[i-1];
      rs_q[0] <= bus.rd_fetch;
      for (int unsigned i = 1; i < RD_LAT; i++) rs_q[i] <= rs_q[i-1];
      a_data_q    <= sel_data;
      a_dqm_n_q   <= ~sel_bena;
      a_oe_q      <= |fe_s;
      dq_o_q      <= a_data_q;
      dqm_n_q     <= a_dqm_n_q;
      dq_oe_q     <= a_oe_q;
      rd_data_q   <= bus.sdram_dq_i;
      err_multi_q <= err_multi_d;
      err_coll_q  <= err_coll_d;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rs_q[RD_LAT-1];
  assign bus.err_multi   = err_multi_q;
  assign bus.err_coll    = err_coll_q;
  assign bus.sdram_dqm_n = dqm_n_q;
  assign bus.sdram_dq_oe = dq_oe_q;
  assign bus.sdram_dq_o  = dq_o_q;
endmodule
